bcd_tick_counter: RTL and testbench

Parametrised successor to the lab's fixed 0–20 push-button counter. It provides:
- a prescaled tick generator;
- an up/down counter with a configurable terminal value, one-shot or wrap mode, pause and restart;
- a DIGITS-wide BCD output for the seven-segment display driver.

It sits between the debounced button/switch inputs and the display scan module.

---
 rtl/bcd_tick_counter_pkg.sv | 31 +++
 rtl/bcd_tick_counter_bin2bcd.sv | 26 ++
 rtl/bcd_tick_counter.sv | 114 +++++++++++
 tb/tb_bcd_tick_counter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_tick_counter_pkg.sv
// Shared definitions for the prescaled BCD tick counter:
// state encoding, count width and parameter legality.
package bcd_tick_counter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t RUN    = 2'd1;
    localparam state_t PAUSED = 2'd2;
    localparam state_t DONE   = 2'd3;

    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    // MAX_COUNT must fit in DIGITS decimal digits.
    function automatic bit params_legal(
        input int max_count,
        input int digits,
        input int tick_div
    );
        longint lim;
        lim = 1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 10;
        end
        return (digits >= 1) && (tick_div >= 2) && (max_count >= 1)
            && (longint'(max_count) <= lim - 1);
    endfunction

endpackage

// File: rtl/bcd_tick_counter_bin2bcd.sv
// Combinational binary to packed-BCD conversion (double dabble).
// Digit 0 occupies bcd_o[3:0].
module bcd_tick_counter_bin2bcd #(
    parameter int W      = 5,
    parameter int DIGITS = 2
) (
    input  logic [W-1:0]        bin_i,
    output logic [4*DIGITS-1:0] bcd_o
);

    logic [4*DIGITS-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = W - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (acc[4*d +: 4] >= 4'd5) begin
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
                end
            end
            acc = {acc[4*DIGITS-2:0], bin_i[i]};
        end
        bcd_o = acc;
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled up/down counter with pause, restart, one-shot or wrap
// mode, and a BCD view of the count for the display scanner.
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int TICK_DIV  = 10000000,
    parameter int MAX_COUNT = 20,
    localparam int CW       = count_width(MAX_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic                dir,
    input  logic                wrap_mode,
    output logic [CW-1:0]       count,
    output logic [4*DIGITS-1:0] bcd,
    output logic                running,
    output logic                done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] MAXV       = CW'(MAX_COUNT);

    if (!params_legal(MAX_COUNT, DIGITS, TICK_DIV)) begin : g_bad_params
        $error("bcd_tick_counter: illegal MAX_COUNT/DIGITS/TICK_DIV");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;

    logic [CW-1:0] term_v;
    logic [CW-1:0] init_v;

    assign term_v = dir_q ? '0 : MAXV;
    assign init_v = dir_q ? MAXV : '0;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;
        if (start) begin
            dir_d   = dir;
            wrap_d  = wrap_mode;
            count_d = dir ? MAXV : '0;
            presc_d = '0;
            state_d = RUN;
        end else if (state_q == RUN || state_q == PAUSED) begin
            if (pause) begin
                state_d = PAUSED;
            end else begin
                // Releasing pause resumes the prescaler in the same cycle.
                state_d = RUN;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (count_q == term_v) begin
                        count_d = init_v;
                    end else begin
                        count_d = dir_q ? count_q - CW'(1)
                                        : count_q + CW'(1);
                        if (count_d == term_v) begin
                            done_d = 1'b1;
                            if (!wrap_q) begin
                                state_d = DONE;
                            end
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign running = (state_q == RUN) || (state_q == PAUSED);

    bcd_tick_counter_bin2bcd #(
        .W      (CW),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .bin_i (count_q),
        .bcd_o (bcd)
    );

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter: vector table, directed
// corner sequences and randomized stimulus against a reference model.
module tb_bcd_tick_counter;

    localparam int DIGITS    = 2;
    localparam int TICK_DIV  = 4;
    localparam int MAX_COUNT = 20;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                pause = 1'b0;
    logic                dir = 1'b0;
    logic                wrap_mode = 1'b0;
    logic [CW-1:0]       count;
    logic [4*DIGITS-1:0] bcd;
    logic                running;
    logic                done;

    int checks = 0;
    int errors = 0;

    // Reference model: count as an integer, progress within the
    // current tick period, and whether the run is still live.
    int m_count = 0;
    int m_phase = 0;
    bit m_live  = 0;
    bit m_dir   = 0;
    bit m_wrap  = 0;
    bit m_done  = 0;

    bcd_tick_counter #(
        .DIGITS    (DIGITS),
        .TICK_DIV  (TICK_DIV),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .dir       (dir),
        .wrap_mode (wrap_mode),
        .count     (count),
        .bcd       (bcd),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int to_bcd(input int v);
        return ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit p,
                              input bit d, input bit w);
        int target;
        m_done = 0;
        if (r) begin
            m_count = 0; m_phase = 0; m_live = 0;
            m_dir = 0; m_wrap = 0;
        end else if (s) begin
            m_dir = d; m_wrap = w;
            m_count = d ? MAX_COUNT : 0;
            m_phase = 0; m_live = 1;
        end else if (m_live && !p) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                target = m_dir ? 0 : MAX_COUNT;
                if (m_count == target) begin
                    m_count = m_dir ? MAX_COUNT : 0;
                end else begin
                    m_count = m_count + (m_dir ? -1 : 1);
                    if (m_count == target) begin
                        m_done = 1;
                        if (!m_wrap) m_live = 0;
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, take the edge, settle, update model.
    task automatic step(input bit r, input bit s, input bit p,
                        input bit d, input bit w);
        rst = r; start = s; pause = p; dir = d; wrap_mode = w;
        @(posedge clk);
        #1;
        model_edge(r, s, p, d, w);
        rst = 0; start = 0; pause = 0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_count"}, int'(count), m_count);
        chk({tag, "_bcd"}, int'(bcd), to_bcd(m_count));
        chk({tag, "_running"}, int'(running), int'(m_live));
        chk({tag, "_done"}, int'(done), int'(m_done));
    endtask

    typedef struct {
        bit rst;
        bit start;
        bit pause;
        bit dir;
        bit wrap;
        int ecount;
        bit erun;
        bit edone;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int e;
        int k;
        bit r, s, p, d, w;

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 1, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 1, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 2, 1, 0};
        tbl[12] = '{0, 1, 0, 1, 0, 20, 1, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 1, 0, 0, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].pause,
                 tbl[i].dir, tbl[i].wrap);
            chk($sformatf("vec%0d_count", i), int'(count), tbl[i].ecount);
            chk($sformatf("vec%0d_bcd", i), int'(bcd), to_bcd(tbl[i].ecount));
            chk($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].erun));
            chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].edone));
        end

        // One-shot up count, then DONE held
        step(0, 1, 0, 0, 0);
        for (int t = 1; t <= 280; t++) begin
            step(0, 0, 0, 0, 0);
            e = (t / 4 > 20) ? 20 : t / 4;
            chk("up_count", int'(count), e);
            chk("up_done", int'(done), int'(t == 80));
            chk("up_running", int'(running), int'(t < 80));
            if (t >= 80) chk("up_bcd_hold", int'(bcd), 8'h20);
        end

        // One-shot down count
        step(0, 1, 0, 1, 0);
        chk("down_initial", int'(count), 20);
        for (int t = 1; t <= 100; t++) begin
            step(0, 0, 0, 0, 0);
            e = 20 - t / 4;
            if (e < 0) e = 0;
            chk("down_count", int'(count), e);
            chk("down_done", int'(done), int'(t == 80));
            if (t >= 80) chk("down_bcd", int'(bcd), 0);
        end

        // Wrap mode: terminal shown one full period, then reload
        step(0, 1, 0, 0, 1);
        for (int t = 1; t <= 170; t++) begin
            step(0, 0, 0, 0, 0);
            k = t % 84;
            chk("wrap_count", int'(count), k / 4);
            chk("wrap_done", int'(done), int'(t == 80 || t == 164));
            chk("wrap_running", int'(running), 1);
        end

        // Pause mid-period
        step(0, 1, 0, 0, 0);
        for (int t = 1; t <= 6; t++) step(0, 0, 0, 0, 0);
        for (int t = 7; t <= 16; t++) begin
            step(0, 0, 1, 0, 0);
            chk("pause_count", int'(count), 1);
            chk("pause_bcd", int'(bcd), 8'h01);
            chk("pause_running", int'(running), 1);
        end
        step(0, 0, 0, 0, 0);
        chk("pause_rel17", int'(count), 1);
        step(0, 0, 0, 0, 0);
        chk("pause_rel18", int'(count), 2);

        // Restart coinciding with a tick at count 7
        step(0, 1, 0, 0, 0);
        for (int t = 1; t <= 31; t++) step(0, 0, 0, 0, 0);
        chk("restart_pre", int'(count), 7);
        step(0, 1, 0, 0, 0);
        chk("restart_count", int'(count), 0);
        chk("restart_done", int'(done), 0);
        for (int t = 1; t <= 4; t++) begin
            step(0, 0, 0, 0, 0);
            chk("restart_presc", int'(count), t / 4);
        end

        // Reset mid-run at count 13
        step(0, 1, 0, 0, 0);
        for (int t = 1; t <= 53; t++) step(0, 0, 0, 0, 0);
        chk("rst_pre", int'(count), 13);
        step(1, 0, 0, 0, 0);
        chk("rst_count", int'(count), 0);
        chk("rst_bcd", int'(bcd), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_done", int'(done), 0);
        for (int t = 1; t <= 20; t++) begin
            step(0, 0, t[0], 0, 0);
            chk("rst_idle_count", int'(count), 0);
            chk("rst_idle_running", int'(running), 0);
        end

        // Randomized stimulus against the model
        for (int t = 0; t < 4000; t++) begin
            r = ($urandom % 300) == 0;
            s = ($urandom % 120) == 0;
            p = ($urandom % 8) < 2;
            d = $urandom % 2;
            w = $urandom % 2;
            step(r, s, p, d, w);
            chk_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
